// File: rtl/tristate_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// tristate_bus_arbiter_if
//
// Bundles the request, source-data and shared-bus signals of the tri-state bus
// arbiter so that the arbiter and the requesting sources see one port.
//
// Parameters
//   WIDTH  : width of each source word and of the shared bus
//   N_SRC  : number of requesting sources
//
// Signals
//   req        [N_SRC-1:0]        per-source bus request (bit i = source i)
//   data_in    [N_SRC*WIDTH-1:0]  packed source words, source i at [i*WIDTH +: WIDTH]
//   bus        [WIDTH-1:0]        shared tri-state bus, all z when not driven
//   grant      [N_SRC-1:0]        registered one-hot owner, all-zero when no owner
//   bus_active                    high while the bus carries a driven word
//
// Modports
//   master : the arbiter (reads requests/data, drives bus/grant/bus_active)
//   slave  : the sources (drive requests/data, observe bus/grant/bus_active)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

interface tristate_bus_arbiter_if #(
    parameter int WIDTH = 9,
    parameter int N_SRC = 4
);
    logic [N_SRC-1:0]       req;
    logic [N_SRC*WIDTH-1:0] data_in;
    wire  [WIDTH-1:0]       bus;
    logic [N_SRC-1:0]       grant;
    logic                   bus_active;

    modport master (
        input  req,
        input  data_in,
        output bus,
        output grant,
        output bus_active
    );

    modport slave (
        output req,
        output data_in,
        input  bus,
        input  grant,
        input  bus_active
    );
endinterface

// File: rtl/tristate_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tristate_bus_arbiter
//
// Round-robin arbiter for a shared tri-state bus. The winning source's word is
// captured into a data register and driven onto the bus for up to MAX_BURST
// consecutive cycles, then the bus is re-arbitrated starting after the owner.
//
// Parameters
//   WIDTH     : width of each source word and of the shared bus (default 9)
//   N_SRC     : number of requesting sources, 2..8 (default 4)
//   MAX_BURST : maximum consecutive drive cycles per grant, 1..15 (default 4)
//
// Ports
//   clk    : clock, all state updates on the rising edge
//   rst_n  : asynchronous active-low reset
//   bif    : tristate_bus_arbiter_if.master (req, data_in in; bus, grant,
//            bus_active out)
//
// Configuration
//   TRISTATE_BUS_TURNAROUND_EN : when defined, every release spends exactly one
//   cycle in a turnaround state (bus z, grant 0) before arbitrating again.
//   When undefined, a release re-arbitrates on the same edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tristate_bus_arbiter #(
    parameter int WIDTH     = 9,
    parameter int N_SRC     = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    tristate_bus_arbiter_if.master bif
);

    localparam int               IDX_W       = $clog2(N_SRC);
    localparam logic [3:0]       BURST_LIMIT = 4'(MAX_BURST);
    localparam logic [IDX_W:0]   N_SRC_W     = (IDX_W + 1)'(N_SRC);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
`ifdef TRISTATE_BUS_TURNAROUND_EN
        ST_TURN  = 2'd2,
`endif
        ST_DRIVE = 2'd1
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   last_owner_q, last_owner_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [N_SRC-1:0]   grant_q, grant_d;

    // Per-source view of the packed data input.
    logic [WIDTH-1:0]   src_word [N_SRC];

    generate
        for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src_word
            assign src_word[gi] = bif.data_in[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Round-robin search. The search begins one past arb_base; while a
    // burst is running that is the current owner (it becomes last_owner on
    // release), otherwise it is the remembered last_owner.
    // ------------------------------------------------------------------
    logic [IDX_W-1:0]   arb_base;
    logic               win_found;
    logic [IDX_W-1:0]   win_idx;

    assign arb_base = (state_q == ST_DRIVE) ? owner_q : last_owner_q;

    always_comb begin : rr_search
        logic [IDX_W:0] cand;
        cand      = '0;
        win_found = 1'b0;
        win_idx   = '0;
        // Walk offsets from farthest to nearest so the nearest requester
        // is the last one written and therefore wins.
        for (int k = N_SRC; k >= 1; k--) begin
            cand = {1'b0, arb_base} + (IDX_W + 1)'(k);
            if (cand >= N_SRC_W) begin
                cand = cand - N_SRC_W;
            end
            if (bif.req[cand[IDX_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IDX_W-1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    logic start_arb;

    always_comb begin : next_state
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        data_d       = data_q;
        cnt_d        = cnt_q;
        grant_d      = grant_q;
        start_arb    = 1'b0;

        case (state_q)
            ST_DRIVE: begin
                if (bif.req[owner_q] && (cnt_q < BURST_LIMIT)) begin
                    // Burst continues: capture the owner's current word.
                    data_d = src_word[owner_q];
                    cnt_d  = cnt_q + 4'd1;
                end else begin
                    // Request dropped and/or burst exhausted: one release.
                    last_owner_d = owner_q;
`ifdef TRISTATE_BUS_TURNAROUND_EN
                    state_d = ST_TURN;
                    grant_d = '0;
`else
                    start_arb = 1'b1;
`endif
                end
            end
`ifdef TRISTATE_BUS_TURNAROUND_EN
            ST_TURN: begin
                start_arb = 1'b1;
            end
`endif
            default: begin
                start_arb = 1'b1;
            end
        endcase

        if (start_arb) begin
            grant_d = '0;
            if (win_found) begin
                state_d          = ST_DRIVE;
                owner_d          = win_idx;
                data_d           = src_word[win_idx];
                cnt_d            = 4'd1;
                grant_d[win_idx] = 1'b1;
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers. last_owner resets to the highest index so that
    // source 0 is first in line after reset.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            owner_q      <= '0;
            last_owner_q <= IDX_W'(N_SRC - 1);
            data_q       <= '0;
            cnt_q        <= '0;
            grant_q      <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            data_q       <= data_d;
            cnt_q        <= cnt_d;
            grant_q      <= grant_d;
        end
    end

    // Outputs come only from registers, so req/data_in never reach the bus
    // combinationally.
    assign bif.bus        = (state_q == ST_DRIVE) ? data_q : {WIDTH{1'bz}};
    assign bif.bus_active = (state_q == ST_DRIVE);
    assign bif.grant      = grant_q;

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tristate_bus_arbiter
//
// Self-checking bench for tristate_bus_arbiter (WIDTH=9, N_SRC=4,
// MAX_BURST=4). Table-driven vectors cover the fixed scenarios, short
// hand-written sequences cover reset behaviour, and a randomized phase is
// compared against a behavioural model of the arbitration rules.
// Honours TRISTATE_BUS_TURNAROUND_EN in its expectations.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_tristate_bus_arbiter;

    localparam int W  = 9;
    localparam int N  = 4;
    localparam int MB = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    tristate_bus_arbiter_if #(.WIDTH(W), .N_SRC(N)) bif ();

    tristate_bus_arbiter #(
        .WIDTH     (W),
        .N_SRC     (N),
        .MAX_BURST (MB)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bif   (bif.master)
    );

    int n_cmp = 0;
    int n_err = 0;

    // ---------------------------------------------------------------
    // Checking helpers
    // ---------------------------------------------------------------
    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [3:0] eg, input logic ea,
                              input logic [8:0] eb);
        cmp({tag, " grant"},  32'(bif.grant),      32'(eg));
        cmp({tag, " active"}, 32'(bif.bus_active), 32'(ea));
        if (ea) cmp({tag, " bus"}, 32'(bif.bus), 32'(eb));
    endtask

    function automatic logic [35:0] pack(input logic [8:0] w0, input logic [8:0] w1,
                                         input logic [8:0] w2, input logic [8:0] w3);
        return {w3, w2, w1, w0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------------------------------------------------------
    // Behavioural model: owner is -1 when nobody holds the bus.
    // ---------------------------------------------------------------
    int          m_owner;
    int          m_cnt;
    int          m_last;
    bit          m_turn;
    logic [8:0]  m_word;

    task automatic model_reset();
        m_owner = -1;
        m_cnt   = 0;
        m_last  = N - 1;
        m_turn  = 1'b0;
        m_word  = '0;
    endtask

    task automatic model_edge(input logic [3:0] r, input logic [35:0] d);
        int w;
        if (m_owner >= 0 && r[m_owner] && m_cnt < MB) begin
            m_cnt++;
            m_word = d[m_owner*W +: W];
            return;
        end
        if (m_owner >= 0) begin
            m_last  = m_owner;
            m_owner = -1;
`ifdef TRISTATE_BUS_TURNAROUND_EN
            m_turn = 1'b1;
            return;
`endif
        end else begin
            m_turn = 1'b0;
        end
        w = -1;
        for (int k = 1; k <= N; k++) begin
            if (w < 0 && r[(m_last + k) % N]) w = (m_last + k) % N;
        end
        if (w >= 0) begin
            m_owner = w;
            m_cnt   = 1;
            m_word  = d[w*W +: W];
        end
    endtask

    function automatic logic [3:0] model_grant();
        return (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
    endfunction

    task automatic do_reset();
        rst_n       = 1'b0;
        bif.req     = '0;
        bif.data_in = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    // ---------------------------------------------------------------
    // Vector table
    // ---------------------------------------------------------------
    typedef struct {
        bit          rst;
        logic [3:0]  req;
        logic [35:0] data;
        logic [3:0]  grant;
        logic        act;
        logic [8:0]  busv;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit rst, input logic [3:0] r, input logic [35:0] d,
                       input logic [3:0] g, input logic a, input logic [8:0] b);
        vec_t v;
        v.rst = rst; v.req = r; v.data = d; v.grant = g; v.act = a; v.busv = b;
        vecs.push_back(v);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [3:0]  ga [12];
        logic [35:0] da;
        logic [3:0]  r;
        logic [35:0] d;
        bit          on;

        bif.req     = '0;
        bif.data_in = '0;
        model_reset();

        // ---- build the table -------------------------------------
        da = pack(9'h100, 9'h111, 9'h122, 9'h133);
`ifdef TRISTATE_BUS_TURNAROUND_EN
        ga = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0100,
               4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0001, 4'b0001};
`else
        ga = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0100, 4'b0100,
               4'b0100, 4'b0100, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`endif
        // Two requesters held: alternating 4-cycle bursts.
        for (int i = 0; i < 12; i++)
            add(i == 0, 4'b0101, da, ga[i], ga[i] != 4'b0000,
                (ga[i] == 4'b0100) ? 9'h122 : 9'h100);

        // Source 2 alone for two cycles, then released.
        add(1'b1, 4'b0100, pack(9'h000, 9'h000, 9'h155, 9'h000), 4'b0100, 1'b1, 9'h155);
        add(1'b0, 4'b0100, pack(9'h000, 9'h000, 9'h0AA, 9'h000), 4'b0100, 1'b1, 9'h0AA);
        add(1'b0, 4'b0000, pack(9'h000, 9'h000, 9'h1FF, 9'h000), 4'b0000, 1'b0, 9'h000);
        add(1'b0, 4'b0000, pack(9'h000, 9'h000, 9'h1FF, 9'h000), 4'b0000, 1'b0, 9'h000);

        // Source 3 sole requester for 10 cycles: bursts of 4, 4, 2.
        for (int i = 1; i <= 11; i++) begin
`ifdef TRISTATE_BUS_TURNAROUND_EN
            on = (i <= 10) && (i != 5) && (i != 10);
`else
            on = (i <= 10);
`endif
            add(i == 1, (i <= 10) ? 4'b1000 : 4'b0000,
                pack(9'h1FF, 9'h1FF, 9'h1FF, 9'(9'h0F0 + i)),
                on ? 4'b1000 : 4'b0000, on, 9'(9'h0F0 + i));
        end

        // ---- reset held with all sources requesting ---------------
        rst_n       = 1'b0;
        bif.req     = 4'b1111;
        bif.data_in = pack(9'h0A5, 9'h05A, 9'h0C3, 9'h03C);
        repeat (3) tick();
        check_outs("reset_held", 4'b0000, 1'b0, 9'h000);
        $display("seq reset_held grant=%b active=%b", bif.grant, bif.bus_active);
        rst_n = 1'b1;
        tick();
        check_outs("reset_release", 4'b0001, 1'b1, 9'h0A5);
        $display("seq reset_release grant=%b bus=%h", bif.grant, bif.bus);

        // ---- table ------------------------------------------------
        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset();
            bif.req     = vecs[i].req;
            bif.data_in = vecs[i].data;
            tick();
            check_outs($sformatf("vec%0d", i), vecs[i].grant, vecs[i].act, vecs[i].busv);
            $display("vec %0d req=%b grant=%b active=%b bus=%h",
                     i, vecs[i].req, bif.grant, bif.bus_active, bif.bus);
        end

        // ---- async reset mid-burst --------------------------------
        do_reset();
        bif.req     = 4'b0010;
        bif.data_in = pack(9'h000, 9'h011, 9'h000, 9'h000);
        tick();
        bif.data_in = pack(9'h000, 9'h012, 9'h000, 9'h000);
        tick();
        check_outs("midburst", 4'b0010, 1'b1, 9'h012);
        #2 rst_n = 1'b0;
        #1;
        check_outs("async_rst", 4'b0000, 1'b0, 9'h000);
        $display("seq async_rst grant=%b active=%b", bif.grant, bif.bus_active);
        #1 rst_n = 1'b1;
        bif.data_in = pack(9'h000, 9'h013, 9'h000, 9'h000);
        tick();
        check_outs("after_rst", 4'b0010, 1'b1, 9'h013);
        $display("seq after_rst grant=%b bus=%h", bif.grant, bif.bus);

        // ---- randomized against the model --------------------------
        do_reset();
        r = '0;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 9) < 3) r = 4'($urandom_range(0, 15));
            d = {4'($urandom), $urandom};
            bif.req     = r;
            bif.data_in = d;
            tick();
            model_edge(r, d);
            check_outs($sformatf("rand%0d", c), model_grant(), m_owner >= 0, m_word);
            $display("rand %0d req=%b grant=%b active=%b bus=%h",
                     c, r, bif.grant, bif.bus_active, bif.bus);
            if ($urandom_range(0, 49) == 0) begin
                #2 rst_n = 1'b0;
                #1;
                model_reset();
                check_outs($sformatf("rand_rst%0d", c), 4'b0000, 1'b0, 9'h000);
                $display("rand %0d async reset pulse", c);
                #1 rst_n = 1'b1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
